call_stack_ctrl: RTL and testbench

CALL_STACK_CTRL -- requirements
Module: call_stack_ctrl

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/ret_stack_mem.sv | 51 +++++
 rtl/call_stack_ctrl.sv | 163 ++++++++++++++++
 tb/tb_call_stack_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : frame tag constants and frame type shared by the call-stack block
// Revision: 1.0
// ============================================================================
package cpu_pkg;

    localparam logic TAG_CALL = 1'b0;
    localparam logic TAG_IRQ  = 1'b1;

    // Address field sized for the widest supported PC (PC_W <= 32).
    localparam int unsigned FRAME_ADDR_W = 32;

    typedef struct packed {
        logic                    tag;
        logic [FRAME_ADDR_W-1:0] addr;
    } frame_t;

endpackage
`default_nettype wire

// File: rtl/ret_stack_mem.sv
`default_nettype none
// ============================================================================
// ret_stack_mem : DEPTH x WIDTH LIFO; storage is not reset, only the depth is
// Revision: 1.0
// ============================================================================
module ret_stack_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   depth
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_depth;
    logic [AW-1:0]    w_top_idx;

    // Wraps to DEPTH-1 when full, which is the correct top slot.
    assign w_top_idx = r_depth[AW-1:0] - AW'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_depth <= '0;
        end else if (clear) begin
            r_depth <= '0;
        end else if (push) begin
            r_depth <= r_depth + (AW+1)'(1);
        end else if (pop) begin
            r_depth <= r_depth - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset && !clear && push) begin
            r_mem[r_depth[AW-1:0]] <= din;
        end
    end

    assign top   = (r_depth == '0) ? '0 : r_mem[w_top_idx];
    assign depth = r_depth;

endmodule
`default_nettype wire

// File: rtl/call_stack_ctrl.sv
`default_nettype none
// ============================================================================
// call_stack_ctrl : next-PC selection with a tagged return stack for
//                   CALL/RET/IRQ/RETI, plus sticky error and high-water tracking
// Revision: 1.0
// ============================================================================
module call_stack_ctrl
    import cpu_pkg::*;
#(
    parameter int              PC_W    = 19,
    parameter int              TGT_W   = 11,
    parameter int              DEPTH   = 16,
    parameter logic [PC_W-1:0] IRQ_VEC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PC_W-1:0]          pc_current,
    input  logic                     call_en,
    input  logic                     ret_en,
    input  logic                     reti_en,
    input  logic [TGT_W-1:0]         call_addr,
    input  logic                     irq_req,
    input  logic                     flush,
    input  logic                     program_end,
    input  logic                     err_clr,
    output logic [PC_W-1:0]          pc_next,
    output logic                     pc_src,
    output logic                     irq_ack,
    output logic [$clog2(DEPTH):0]   depth,
    output logic [$clog2(DEPTH):0]   high_water,
    output logic                     stack_full,
    output logic                     stack_empty,
    output logic                     err_ovf,
    output logic                     err_unf,
    output logic                     err_tag,
    output logic [PC_W-1:0]          top_addr
);

    localparam int          AW     = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    logic [PC_W:0]   w_din;
    logic [PC_W:0]   w_top_raw;
    logic [PC_W-1:0] w_pc_inc;
    logic [AW:0]     w_depth_inc;
    frame_t          w_top;
    logic            w_unused_top;
    logic            w_push, w_pop, w_clear;
    logic            w_set_ovf, w_set_unf, w_set_tag;
    logic            r_ovf, r_unf, r_tag;
    logic [AW:0]     r_hw;

    ret_stack_mem #(
        .DEPTH (DEPTH),
        .WIDTH (PC_W + 1)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .clear (w_clear),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .top   (w_top_raw),
        .depth (depth)
    );

    assign w_top.tag    = w_top_raw[PC_W];
    assign w_top.addr   = FRAME_ADDR_W'(w_top_raw[PC_W-1:0]);
    assign w_unused_top = ^w_top.addr;
    assign top_addr     = w_top.addr[PC_W-1:0];

    assign w_pc_inc    = pc_current + PC_W'(1);
    assign w_depth_inc = depth + (AW+1)'(1);
    assign stack_full  = (depth == C_FULL);
    assign stack_empty = (depth == '0);

    // Only the highest-priority event acts; the rest are ignored this cycle.
    always_comb begin
        pc_next   = w_pc_inc;
        pc_src    = 1'b0;
        irq_ack   = 1'b0;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_clear   = 1'b0;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        w_set_tag = 1'b0;
        w_din     = {TAG_CALL, w_pc_inc};
        if (program_end) begin
            pc_next = pc_current;
        end else if (flush) begin
            w_clear = 1'b1;
        end else if (irq_req) begin
            if (stack_full) begin
                w_set_ovf = 1'b1;
            end else begin
                w_push  = 1'b1;
                w_din   = {TAG_IRQ, pc_current};
                pc_next = IRQ_VEC;
                pc_src  = 1'b1;
                irq_ack = 1'b1;
            end
        end else if (call_en) begin
            if (stack_full) begin
                w_set_ovf = 1'b1;
            end else begin
                w_push  = 1'b1;
                pc_next = PC_W'(call_addr);
                pc_src  = 1'b1;
            end
        end else if (ret_en) begin
            if (stack_empty) begin
                w_set_unf = 1'b1;
            end else if (w_top.tag != TAG_CALL) begin
                w_set_tag = 1'b1;
            end else begin
                w_pop   = 1'b1;
                pc_next = top_addr;
                pc_src  = 1'b1;
            end
        end else if (reti_en) begin
            if (stack_empty) begin
                w_set_unf = 1'b1;
            end else if (w_top.tag != TAG_IRQ) begin
                w_set_tag = 1'b1;
            end else begin
                w_pop   = 1'b1;
                pc_next = top_addr;
                pc_src  = 1'b1;
            end
        end
    end

    // A new error in the same cycle as err_clr keeps its flag set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            r_tag <= 1'b0;
        end else begin
            r_ovf <= w_set_ovf | (r_ovf & ~err_clr);
            r_unf <= w_set_unf | (r_unf & ~err_clr);
            r_tag <= w_set_tag | (r_tag & ~err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hw <= '0;
        end else if (w_clear) begin
            r_hw <= '0;
        end else if (w_push && (w_depth_inc > r_hw)) begin
            r_hw <= w_depth_inc;
        end
    end

    assign err_ovf    = r_ovf;
    assign err_unf    = r_unf;
    assign err_tag    = r_tag;
    assign high_water = r_hw;

endmodule
`default_nettype wire

// File: tb/tb_call_stack_ctrl.sv
`default_nettype none
// ============================================================================
// tb_call_stack_ctrl : table-driven directed vectors plus overflow/flush runs
// Revision: 1.0
// ============================================================================
module tb_call_stack_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [18:0] pc_current;
    logic        call_en, ret_en, reti_en, irq_req, flush, program_end, err_clr;
    logic [10:0] call_addr;
    logic [18:0] pc_next, top_addr;
    logic        pc_src, irq_ack, stack_full, stack_empty;
    logic        err_ovf, err_unf, err_tag;
    logic [4:0]  depth, high_water;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    call_stack_ctrl #(
        .PC_W    (19),
        .TGT_W   (11),
        .DEPTH   (16),
        .IRQ_VEC (19'h00040)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_current  (pc_current),
        .call_en     (call_en),
        .ret_en      (ret_en),
        .reti_en     (reti_en),
        .call_addr   (call_addr),
        .irq_req     (irq_req),
        .flush       (flush),
        .program_end (program_end),
        .err_clr     (err_clr),
        .pc_next     (pc_next),
        .pc_src      (pc_src),
        .irq_ack     (irq_ack),
        .depth       (depth),
        .high_water  (high_water),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .err_ovf     (err_ovf),
        .err_unf     (err_unf),
        .err_tag     (err_tag),
        .top_addr    (top_addr)
    );

    typedef struct {
        logic        rst_n, call, ret, reti, irq, fl, pend, clr;
        logic [18:0] pc;
        logic [10:0] addr;
        logic [18:0] e_pc;
        logic        e_src, e_ack;
        logic [4:0]  e_depth;
        logic [18:0] e_top;
        logic [4:0]  e_hw;
        logic        e_ovf, e_unf, e_tag;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(
        input logic rst_n, call, ret, reti, irq, fl, pend, clr,
        input logic [18:0] pc, input logic [10:0] addr,
        input logic [18:0] e_pc, input logic e_src, e_ack,
        input logic [4:0] e_depth, input logic [18:0] e_top, input logic [4:0] e_hw,
        input logic e_ovf, e_unf, e_tag);
        vec_t v;
        v.rst_n = rst_n; v.call = call; v.ret = ret; v.reti = reti;
        v.irq = irq; v.fl = fl; v.pend = pend; v.clr = clr;
        v.pc = pc; v.addr = addr; v.e_pc = e_pc; v.e_src = e_src; v.e_ack = e_ack;
        v.e_depth = e_depth; v.e_top = e_top; v.e_hw = e_hw;
        v.e_ovf = e_ovf; v.e_unf = e_unf; v.e_tag = e_tag;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge; outputs settle 1ns later.
    task automatic step(input logic rst_n, call, ret, reti, irq, fl, pend, clr,
                        input logic [18:0] pc, input logic [10:0] addr);
        @(negedge clk);
        reset       = rst_n;
        call_en     = call;
        ret_en      = ret;
        reti_en     = reti;
        irq_req     = irq;
        flush       = fl;
        program_end = pend;
        err_clr     = clr;
        pc_current  = pc;
        call_addr   = addr;
        #1;
    endtask

    initial begin
        //             rst call ret reti irq fl pend clr  pc        addr     e_pc      src ack dep e_top     hw ovf unf tag
        vecs[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 19'h00010, 11'h0A5, 19'h000A5, 1, 0, 0, 19'h00000, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 19'h000A5, 11'h000, 19'h000A6, 0, 0, 1, 19'h00011, 1, 0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 0, 1, 0, 0, 0, 19'h00200, 11'h123, 19'h00040, 1, 1, 1, 19'h00011, 1, 0, 0, 0);
        vecs[3]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 19'h00040, 11'h000, 19'h00041, 0, 0, 2, 19'h00200, 2, 0, 0, 0);
        vecs[4]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 19'h00041, 11'h000, 19'h00200, 1, 0, 2, 19'h00200, 2, 0, 0, 1);
        vecs[5]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 19'h00200, 11'h000, 19'h00201, 0, 0, 1, 19'h00011, 2, 0, 0, 1);
        vecs[6]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 19'h00201, 11'h000, 19'h00011, 1, 0, 1, 19'h00011, 2, 0, 0, 1);
        vecs[7]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 19'h00011, 11'h000, 19'h00012, 0, 0, 0, 19'h00000, 2, 0, 0, 1);
        vecs[8]  = mk(1, 0, 1, 0, 0, 0, 0, 1, 19'h00012, 11'h000, 19'h00013, 0, 0, 0, 19'h00000, 2, 0, 1, 1);
        vecs[9]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 19'h00013, 11'h000, 19'h00014, 0, 0, 0, 19'h00000, 2, 0, 1, 0);
        vecs[10] = mk(1, 0, 0, 0, 1, 0, 1, 0, 19'h00014, 11'h000, 19'h00014, 0, 0, 0, 19'h00000, 2, 0, 0, 0);
        vecs[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, 19'h7FFFF, 11'h000, 19'h00000, 0, 0, 0, 19'h00000, 2, 0, 0, 0);
        vecs[12] = mk(0, 1, 0, 0, 0, 0, 0, 0, 19'h00030, 11'h7FF, 19'h007FF, 1, 0, 0, 19'h00000, 2, 0, 0, 0);
        vecs[13] = mk(1, 0, 0, 0, 0, 0, 0, 0, 19'h00031, 11'h000, 19'h00032, 0, 0, 0, 19'h00000, 0, 0, 0, 0);
        vecs[14] = mk(1, 0, 0, 1, 0, 0, 0, 0, 19'h00032, 11'h000, 19'h00033, 0, 0, 0, 19'h00000, 0, 0, 0, 0);

        reset = 1'b0; call_en = 0; ret_en = 0; reti_en = 0; irq_req = 0;
        flush = 0; program_end = 0; err_clr = 0; pc_current = '0; call_addr = '0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].call, vecs[i].ret, vecs[i].reti, vecs[i].irq,
                 vecs[i].fl, vecs[i].pend, vecs[i].clr, vecs[i].pc, vecs[i].addr);
            chk($sformatf("v%0d pc_next", i), 32'(pc_next),    32'(vecs[i].e_pc));
            chk($sformatf("v%0d pc_src", i),  32'(pc_src),     32'(vecs[i].e_src));
            chk($sformatf("v%0d irq_ack", i), 32'(irq_ack),    32'(vecs[i].e_ack));
            chk($sformatf("v%0d depth", i),   32'(depth),      32'(vecs[i].e_depth));
            chk($sformatf("v%0d top", i),     32'(top_addr),   32'(vecs[i].e_top));
            chk($sformatf("v%0d hw", i),      32'(high_water), 32'(vecs[i].e_hw));
            chk($sformatf("v%0d empty", i),   32'(stack_empty), 32'(vecs[i].e_depth == 5'd0));
            chk($sformatf("v%0d flags", i),   32'({err_ovf, err_unf, err_tag}),
                32'({vecs[i].e_ovf, vecs[i].e_unf, vecs[i].e_tag}));
        end

        // Fill to 16, then overflow via call and via irq.
        step(0, 0, 0, 0, 0, 0, 0, 0, 19'h0, 11'h0);
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 0, 0, 0, 0, 0, 0, 19'(32'h100 + i), 11'(i));
            chk($sformatf("fill%0d pc_next", i), 32'(pc_next), 32'(i));
            chk($sformatf("fill%0d depth", i),   32'(depth),   32'(i));
        end
        step(1, 1, 0, 0, 0, 0, 0, 0, 19'h00300, 11'h055);
        chk("ovf pc_next", 32'(pc_next), 32'h301);
        chk("ovf pc_src",  32'(pc_src), 32'h0);
        chk("ovf full",    32'(stack_full), 32'h1);
        chk("ovf depth",   32'(depth), 32'd16);
        chk("ovf hw",      32'(high_water), 32'd16);
        chk("ovf top",     32'(top_addr), 32'h110);
        chk("ovf pre flag", 32'(err_ovf), 32'h0);
        step(1, 0, 0, 0, 1, 0, 0, 0, 19'h00400, 11'h000);
        chk("irqfull pc_next", 32'(pc_next), 32'h401);
        chk("irqfull ack",     32'(irq_ack), 32'h0);
        chk("ovf flag",        32'(err_ovf), 32'h1);
        step(1, 0, 1, 0, 0, 0, 0, 0, 19'h00500, 11'h000);
        chk("full ret pc_next", 32'(pc_next), 32'h110);
        chk("full ret depth",   32'(depth), 32'd16);
        step(1, 0, 0, 0, 0, 1, 0, 0, 19'h00600, 11'h000);
        chk("flush pc_next", 32'(pc_next), 32'h601);
        chk("flush pc_src",  32'(pc_src), 32'h0);
        chk("flush pre depth", 32'(depth), 32'd15);
        chk("flush pre top",   32'(top_addr), 32'h10F);
        step(1, 0, 0, 0, 0, 0, 0, 0, 19'h00601, 11'h000);
        chk("flush depth", 32'(depth), 32'd0);
        chk("flush hw",    32'(high_water), 32'd0);
        chk("flush keeps ovf", 32'(err_ovf), 32'h1);

        // Flush at depth 5.
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 0, 0, 0, 0, 0, 19'(32'h20 + i), 11'(32'h80 + i));
        end
        step(1, 0, 0, 0, 0, 1, 0, 0, 19'h00700, 11'h000);
        chk("d5 depth", 32'(depth), 32'd5);
        chk("d5 hw",    32'(high_water), 32'd5);
        chk("d5 top",   32'(top_addr), 32'h25);
        step(1, 0, 0, 0, 0, 0, 0, 0, 19'h7FFFF, 11'h000);
        chk("d5 flush depth", 32'(depth), 32'd0);
        chk("d5 flush hw",    32'(high_water), 32'd0);
        chk("wrap pc_next",   32'(pc_next), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
